pi_math_seq: RTL and testbench

PI_MATH_SEQ -- requirements
Module: pi_math_seq

---
 rtl/pi_math_seq.sv | 114 +++++++++++
 tb/tb_pi_math_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_math_seq.sv
// PI compensator sequencer: walks a shared external ALU through the PI update, one state per cycle.
// Optional build macro INTG_DECIM_EN: the integrator is only written on every fourth sequence.
module pi_math_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [11:0]        Fwd,
  input  logic [11:0]        A2D_res,
  input  logic [15:0]        dst,
  output logic [2:0]         src1sel,
  output logic [2:0]         src0sel,
  output logic               multiply,
  output logic               sub,
  output logic               mult2,
  output logic               mult4,
  output logic               saturate,
  output logic signed [11:0] Error,
  output logic signed [11:0] Intgrl,
  output logic signed [11:0] Icomp,
  output logic [15:0]        Pcomp,
  output logic [15:0]        Accum,
  output logic               busy,
  output logic               done,
  output logic signed [11:0] drive
);

  typedef enum logic [2:0] {IDLE, ERR, INTG, ICMP, PCMP, ACC1, ACC2} state_t;

  state_t state;
  state_t nxt_state;
  logic   intg_wr;

  // Fwd and A2D_res are routed to the ALU directly; they only pass through this block's interface.
  logic unused_ins;
  assign unused_ins = ^{Fwd, A2D_res};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (go) nxt_state = ERR;
      ERR:     nxt_state = INTG;
      INTG:    nxt_state = ICMP;
      ICMP:    nxt_state = PCMP;
      PCMP:    nxt_state = ACC1;
      ACC1:    nxt_state = ACC2;
      ACC2:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // ALU controls decode straight from the state register, so they change only on clock edges.
  always_comb begin
    src1sel  = 3'd0;
    src0sel  = 3'd0;
    multiply = 1'b0;
    sub      = 1'b0;
    mult2    = 1'b0;
    mult4    = 1'b0;
    saturate = 1'b0;
    busy     = (state != IDLE);
    case (state)
      ERR:  begin src1sel = 3'd4; src0sel = 3'd0; sub = 1'b1; saturate = 1'b1; end
      INTG: begin src1sel = 3'd3; src0sel = 3'd1; saturate = 1'b1; end
      ICMP: begin src1sel = 3'd1; src0sel = 3'd1; multiply = 1'b1; end
      PCMP: begin src1sel = 3'd2; src0sel = 3'd4; multiply = 1'b1; end
      ACC1: begin src1sel = 3'd4; src0sel = 3'd3; sub = 1'b1; saturate = 1'b1; end
      ACC2: begin src1sel = 3'd0; src0sel = 3'd2; saturate = 1'b1; end
      default: ;
    endcase
  end

`ifdef INTG_DECIM_EN
  logic [1:0] decim_cnt;

  always_ff @(posedge clk) begin
    if (rst)                decim_cnt <= 2'd0;
    else if (state == ACC2) decim_cnt <= decim_cnt + 2'd1;
  end

  assign intg_wr = (decim_cnt == 2'd3);
`else
  assign intg_wr = 1'b1;
`endif

  // Each operand register captures the ALU result as its own state is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      Error  <= '0;
      Intgrl <= '0;
      Icomp  <= '0;
      Pcomp  <= '0;
      Accum  <= '0;
      drive  <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == ACC2);
      case (state)
        ERR:  Error <= dst[11:0];
        INTG: if (intg_wr) Intgrl <= dst[11:0];
        ICMP: Icomp <= dst[11:0];
        PCMP: Pcomp <= dst;
        ACC1: Accum <= dst;
        ACC2: drive <= dst[11:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_math_seq.sv
// Bench for pi_math_seq: a behavioural ALU drives dst, a PI reference model fills a scoreboard
// that a monitor drains on every done pulse, alongside per-cycle control and status checks.
`timescale 1ns/1ps
module tb_pi_math_seq;

  localparam int ITERM = 1280;
  localparam int PTERM = 12288;
`ifdef INTG_DECIM_EN
  localparam bit DECIM_EN = 1'b1;
`else
  localparam bit DECIM_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               go;
  logic [11:0]        Fwd;
  logic [11:0]        A2D_res;
  logic [15:0]        dst;
  logic [2:0]         src1sel;
  logic [2:0]         src0sel;
  logic               multiply;
  logic               sub;
  logic               mult2;
  logic               mult4;
  logic               saturate;
  logic signed [11:0] Error;
  logic signed [11:0] Intgrl;
  logic signed [11:0] Icomp;
  logic [15:0]        Pcomp;
  logic [15:0]        Accum;
  logic               busy;
  logic               done;
  logic signed [11:0] drive;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pi_math_seq dut (
    .clk(clk), .rst(rst), .go(go), .Fwd(Fwd), .A2D_res(A2D_res), .dst(dst),
    .src1sel(src1sel), .src0sel(src0sel), .multiply(multiply), .sub(sub),
    .mult2(mult2), .mult4(mult4), .saturate(saturate),
    .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp), .Pcomp(Pcomp), .Accum(Accum),
    .busy(busy), .done(done), .drive(drive)
  );

  function automatic int sat12(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Stand-in for the shared ALU: operand muxes, add/sub/multiply (Q12 product) and 12-bit saturation.
  int alu_s1, alu_s0, alu_r;
  always_comb begin
    case (src1sel)
      3'd0:    alu_s1 = int'($signed(Accum));
      3'd1:    alu_s1 = ITERM;
      3'd2:    alu_s1 = int'(Error);
      3'd3:    alu_s1 = int'(Error) >>> 4;
      3'd4:    alu_s1 = int'(Fwd);
      default: alu_s1 = 0;
    endcase
    case (src0sel)
      3'd0:    alu_s0 = int'(A2D_res);
      3'd1:    alu_s0 = int'(Intgrl);
      3'd2:    alu_s0 = int'(Icomp);
      3'd3:    alu_s0 = int'($signed(Pcomp));
      3'd4:    alu_s0 = PTERM;
      default: alu_s0 = 0;
    endcase
    if (multiply)  alu_r = (alu_s1 * alu_s0) >>> 12;
    else if (sub)  alu_r = alu_s1 - alu_s0;
    else           alu_r = alu_s1 + alu_s0;
    if (mult2)     alu_r = alu_r * 2;
    if (mult4)     alu_r = alu_r * 4;
    if (saturate)  alu_r = sat12(alu_r);
    dst = alu_r[15:0];
  end

  typedef struct {
    logic [11:0] err;
    logic [11:0] intg;
    logic [11:0] icomp;
    logic [15:0] pcomp;
    logic [15:0] accum;
    logic [11:0] drv;
    int          intg_val;
  } exp_t;

  exp_t sb_q[$];

  // The PI update expressed directly as arithmetic on the sampled inputs and integrator history.
  function automatic exp_t predict(input int fwd, input int a2d, input int intg_prev, input int decim);
    exp_t e;
    int err, intg, icomp, pcomp, accum, drv;
    err  = sat12(fwd - a2d);
    intg = intg_prev;
    if (!DECIM_EN || decim == 3) intg = sat12(intg_prev + (err >>> 4));
    icomp = (ITERM * intg) >>> 12;
    pcomp = (err * PTERM) >>> 12;
    accum = sat12(fwd - pcomp);
    drv   = sat12(accum + icomp);
    e.err      = err[11:0];
    e.intg     = intg[11:0];
    e.icomp    = icomp[11:0];
    e.pcomp    = pcomp[15:0];
    e.accum    = accum[15:0];
    e.drv      = drv[11:0];
    e.intg_val = intg;
    return e;
  endfunction

  function automatic logic [15:0] ctrl_exp(input int p);
    case (p)
      1:       return {5'd0, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      2:       return {5'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      3:       return {5'd0, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      4:       return {5'd0, 3'd2, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      5:       return {5'd0, 3'd4, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      6:       return {5'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      default: return 16'd0;
    endcase
  endfunction

  // Sequence timing model: phase 0 is idle, 1..6 are the six working steps; go counts only when idle.
  int          phase = 0;
  int          ref_intgrl = 0;
  int          ref_decim = 0;
  logic        exp_done = 1'b0;
  logic [11:0] held_drive = 12'd0;
  logic [11:0] pending_drive = 12'd0;

  always @(posedge clk) begin : ref_model
    exp_t e;
    if (rst) begin
      phase      <= 0;
      ref_intgrl <= 0;
      ref_decim  <= 0;
      exp_done   <= 1'b0;
      held_drive <= 12'd0;
      sb_q.delete();
    end else begin
      exp_done <= (phase == 6);
      if (phase == 6) begin
        phase      <= 0;
        held_drive <= pending_drive;
      end else if (phase != 0) begin
        phase <= phase + 1;
      end else if (go) begin
        e = predict(int'(Fwd), int'(A2D_res), ref_intgrl, ref_decim);
        sb_q.push_back(e);
        ref_intgrl    <= e.intg_val;
        ref_decim     <= (ref_decim + 1) % 4;
        pending_drive <= e.drv;
        phase         <= 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    checkOutput("ctrl", {5'd0, src1sel, src0sel, multiply, sub, mult2, mult4, saturate, busy},
                ctrl_exp(phase));
    checkOutput("done", {15'd0, done}, {15'd0, exp_done});
    checkOutput("drive_held", {4'h0, drive}, {4'h0, held_drive});
    if (done) begin
      checkOutput("sb_pending", 16'(sb_q.size()), 16'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("sb_error",  {4'h0, Error},  {4'h0, e.err});
        checkOutput("sb_intgrl", {4'h0, Intgrl}, {4'h0, e.intg});
        checkOutput("sb_icomp",  {4'h0, Icomp},  {4'h0, e.icomp});
        checkOutput("sb_pcomp",  Pcomp,          e.pcomp);
        checkOutput("sb_accum",  Accum,          e.accum);
        checkOutput("sb_drive",  {4'h0, drive},  {4'h0, e.drv});
      end
    end
  end

  task automatic applyStimulus(input logic [11:0] fwd, input logic [11:0] a2d, input int go_cycles);
    Fwd     = fwd;
    A2D_res = a2d;
    go      = 1'b1;
    repeat (go_cycles) @(negedge clk);
    go = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_error"},  {4'h0, Error},  16'h0000);
    checkOutput({tag, "_intgrl"}, {4'h0, Intgrl}, 16'h0000);
    checkOutput({tag, "_icomp"},  {4'h0, Icomp},  16'h0000);
    checkOutput({tag, "_pcomp"},  Pcomp,          16'h0000);
    checkOutput({tag, "_accum"},  Accum,          16'h0000);
    checkOutput({tag, "_drive"},  {4'h0, drive},  16'h0000);
    checkOutput({tag, "_done"},   {15'd0, done},  16'h0000);
    checkOutput({tag, "_busy"},   {15'd0, busy},  16'h0000);
  endtask

  logic [15:0] intg_seq [4];
  logic [15:0] nominal_drive;
  logic [15:0] nominal_intgrl;
  logic [15:0] nominal_icomp;

  initial begin
    if (DECIM_EN) begin
      intg_seq[0] = 16'h000; intg_seq[1] = 16'h000; intg_seq[2] = 16'h000; intg_seq[3] = 16'h010;
      nominal_drive = 16'h100; nominal_intgrl = 16'h000; nominal_icomp = 16'h000;
    end else begin
      intg_seq[0] = 16'h010; intg_seq[1] = 16'h020; intg_seq[2] = 16'h030; intg_seq[3] = 16'h040;
      nominal_drive = 16'h105; nominal_intgrl = 16'h010; nominal_icomp = 16'h005;
    end

    rst = 1'b1; go = 1'b0; Fwd = 12'd0; A2D_res = 12'd0;
    repeat (3) @(negedge clk);
    checkReset("por");
    rst = 1'b0;

    // Nominal sequence: done lands on the seventh cycle after go was raised.
    applyStimulus(12'h400, 12'h300, 1);
    repeat (6) @(negedge clk);
    checkOutput("nom_done",   {15'd0, done},  16'h0001);
    checkOutput("nom_error",  {4'h0, Error},  16'h0100);
    checkOutput("nom_intgrl", {4'h0, Intgrl}, nominal_intgrl);
    checkOutput("nom_icomp",  {4'h0, Icomp},  nominal_icomp);
    checkOutput("nom_pcomp",  Pcomp,          16'h0300);
    checkOutput("nom_accum",  Accum,          16'h0100);
    checkOutput("nom_drive",  {4'h0, drive},  nominal_drive);

    // Negative saturation of the error term.
    applyStimulus(12'h000, 12'hFFF, 1);
    repeat (6) @(negedge clk);
    checkOutput("negsat_error", {4'h0, Error}, 16'h0800);

    // go while busy is dropped; go held high restarts every seventh cycle.
    applyStimulus(12'h123, 12'h0A0, 1);
    repeat (2) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2) @(negedge clk);
    applyStimulus(12'h200, 12'h250, 21);
    repeat (3) @(negedge clk);

    // Reset while in PCMP aborts without a done pulse, then a clean run follows.
    applyStimulus(12'h300, 12'h100, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("abort");
    applyStimulus(12'h400, 12'h300, 1);
    repeat (6) @(negedge clk);
    checkOutput("post_abort_drive", {4'h0, drive}, nominal_drive);

    // Four back-to-back sequences show the integrator accumulating (or decimating).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    Fwd = 12'h400; A2D_res = 12'h300; go = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (7) @(negedge clk);
      checkOutput($sformatf("b2b_intgrl_%0d", k), {4'h0, Intgrl}, intg_seq[k]);
    end
    go = 1'b0;
    repeat (2) @(negedge clk);

    // Randomised operands, with stray go pulses while the sequence is running.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1);
      for (int j = 0; j < 6; j++) begin
        go = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      go = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
